// File: rtl/pattern_loader_pkg.sv
// Shared definitions for the grid pattern loader: FSM encoding, pattern codes,
// default grid geometry and small helpers.
package pattern_loader_pkg;

  localparam int DEFAULT_ROWS = 8;
  localparam int DEFAULT_COLS = 8;

  localparam logic [1:0] CLEAR   = 2'b00;
  localparam logic [1:0] GLIDER  = 2'b01;
  localparam logic [1:0] BLINKER = 2'b10;
  localparam logic [1:0] BLOCK   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Row index width; a single-row grid still needs a one-bit address.
  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic logic [3:0] code_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// Row-write channel from the pattern loader into the grid memory.
interface pattern_loader_if
  import pattern_loader_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) ();
  localparam int AW = addr_width(ROWS);

  // Handshake: a write transfers on a rising edge where wr_en=1 and wr_ready=1.
  // Once wr_en is raised, wr_addr/wr_data stay stable until that transfer;
  // wr_ready may toggle freely and never depends on anything but the memory.
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [COLS-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/pattern_rom.sv
// Combinational pattern table: one row of a seed pattern per (code, row).
// Bit COLS-1 is column 0, so 0x20 marks the third cell from the left.
module pattern_rom
  import pattern_loader_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) (
  input  logic [1:0]                code,
  input  logic [addr_width(ROWS)-1:0] row,
  output logic [COLS-1:0]           data
);

  always_comb begin
    data = '0;
    case (code)
      GLIDER: begin
        case (int'(row))
          0: data = COLS'(8'h20);
          1: data = COLS'(8'h10);
          2: data = COLS'(8'h70);
          default: data = '0;
        endcase
      end
      BLINKER: begin
        if (int'(row) == 3) data = COLS'(8'h38);
      end
      BLOCK: begin
        if (int'(row) == 3 || int'(row) == 4) data = COLS'(8'h18);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/pattern_loader.sv
// Writes one seed pattern into the grid memory, row 0 first, one row per
// accepted write, then pulses done for a cycle.
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       pattern,
  pattern_loader_if.master wr,
  output logic             busy,
  output logic             done,
  output logic [3:0]       pattern_q,
  output state_t           state_dbg
);

  localparam int AW = addr_width(ROWS);

  state_t          state_q, state_d;
  logic [AW-1:0]   row_q;
  logic [1:0]      code_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [COLS-1:0] wr_data_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      pattern_q_q;

  logic            write_fire;
  logic            last_row;
  logic [AW-1:0]   rom_row;
  logic [COLS-1:0] rom_data;

  assign write_fire = wr_en_q & wr.wr_ready;
  assign last_row   = (row_q == AW'(ROWS - 1));
  // Once a write is on the bus, look ahead to the row that follows it.
  assign rom_row    = wr_en_q ? row_q + AW'(1) : row_q;

  pattern_rom #(.ROWS(ROWS), .COLS(COLS)) u_rom (
    .code (code_q),
    .row  (rom_row),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (write_fire && last_row) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      code_q      <= CLEAR;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pattern_q_q <= 4'b0001;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            code_q      <= pattern;
            pattern_q_q <= code_onehot(pattern);
            row_q       <= '0;
          end
        end
        ST_LOAD: begin
          // First LOAD cycle only registers row 0 onto the bus.
          if (!wr_en_q) begin
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            wr_addr_q <= row_q;
            wr_data_q <= rom_data;
          end else if (wr.wr_ready) begin
            if (last_row) begin
              wr_en_q   <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= '0;
            end else begin
              row_q     <= row_q + AW'(1);
              wr_addr_q <= row_q + AW'(1);
              wr_data_q <= rom_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pattern_q  = pattern_q_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: row-write scoreboard plus per-cycle
// checks of handshake, status outputs and FSM state.
module tb_pattern_loader;
  import pattern_loader_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int AW   = 3;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] pattern;
  logic       busy;
  logic       done;
  logic [3:0] pattern_q;
  state_t     state_dbg;

  pattern_loader_if #(.ROWS(ROWS), .COLS(COLS)) wr_if ();

  pattern_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .wr        (wr_if),
    .busy      (busy),
    .done      (done),
    .pattern_q (pattern_q),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int write_count = 0;
  int done_count  = 0;
  logic [AW+COLS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted write must match the head of exp_q
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (wr_if.wr_en === 1'b1 && wr_if.wr_ready === 1'b1 && reset === 1'b0) begin
      write_count++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("write_addr_data", 32'({wr_if.wr_addr, wr_if.wr_data}), 32'(exp_q.pop_front()));
    end
  end

  // One complete load; rows holds row 0 in its top byte.
  task automatic run_load(input logic [1:0] code, input logic [63:0] rows,
                          input logic [3:0] exp_pq, input int stall_row,
                          input int stall_len, input int glitch_row,
                          input bit keep_start);
    int base_w;
    int base_d;
    logic [7:0] rd;
    base_w = write_count;
    base_d = done_count;
    for (int k = 0; k < ROWS; k++) begin
      rd = rows[63-8*k -: 8];
      exp_q.push_back({AW'(k), rd});
    end
    pattern = code;
    start   = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    check("enter_load_state", 32'(state_dbg), 32'(ST_LOAD));
    check("first_cycle_wr_en", 32'(wr_if.wr_en), 32'd0);
    check("first_cycle_busy", 32'(busy), 32'd0);
    check("latched_pattern_q", 32'(pattern_q), 32'(exp_pq));
    for (int k = 0; k < ROWS; k++) begin
      tick();
      rd = rows[63-8*k -: 8];
      check("row_wr_en", 32'(wr_if.wr_en), 32'd1);
      check("row_addr", 32'(wr_if.wr_addr), 32'(k));
      check("row_data", 32'(wr_if.wr_data), 32'(rd));
      check("row_busy", 32'(busy), 32'd1);
      check("row_pattern_q", 32'(pattern_q), 32'(exp_pq));
      if (k == glitch_row) begin
        pattern = CLEAR;
        start   = 1'b1;
      end
      if (k == glitch_row + 1) start = 1'b0;
      if (k == stall_row) begin
        wr_if.wr_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          check("stall_wr_en", 32'(wr_if.wr_en), 32'd1);
          check("stall_addr", 32'(wr_if.wr_addr), 32'(k));
          check("stall_data", 32'(wr_if.wr_data), 32'(rd));
        end
        wr_if.wr_ready = 1'b1;
      end
    end
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_wr_en", 32'(wr_if.wr_en), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_state", 32'(state_dbg), 32'(ST_DONE));
    tick();
    check("done_cleared", 32'(done), 32'd0);
    check("back_to_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("idle_pattern_q", 32'(pattern_q), 32'(exp_pq));
    check("write_total", 32'(write_count - base_w), 32'd8);
    check("done_pulses", 32'(done_count - base_d), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base_w;
    int base_d;
    reset          = 1'b1;
    start          = 1'b0;
    pattern        = 2'b00;
    wr_if.wr_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    check("reset_wr_en", 32'(wr_if.wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_if.wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_if.wr_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pattern_q", 32'(pattern_q), 32'b0001);

    // glider, memory always ready
    run_load(GLIDER, 64'h20_10_70_00_00_00_00_00, 4'b0010, -1, 0, -1, 1'b0);

    // blinker, three not-ready cycles while row 3 is presented
    run_load(BLINKER, 64'h00_00_00_38_00_00_00_00, 4'b0100, 3, 3, -1, 1'b0);

    // block, pattern changed and start re-pulsed mid-load
    run_load(BLOCK, 64'h00_00_00_18_18_00_00_00, 4'b1000, -1, 0, 2, 1'b0);
    tick();
    check("no_restart_state", 32'(state_dbg), 32'(ST_IDLE));
    check("no_restart_pattern_q", 32'(pattern_q), 32'b1000);

    // glider aborted by reset while row 5 is on the bus
    base_w = write_count;
    base_d = done_count;
    pattern = GLIDER;
    start   = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back({3'd0, 8'h20});
    exp_q.push_back({3'd1, 8'h10});
    exp_q.push_back({3'd2, 8'h70});
    exp_q.push_back({3'd3, 8'h00});
    exp_q.push_back({3'd4, 8'h00});
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_row_addr", 32'(wr_if.wr_addr), 32'(k));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_wr_en", 32'(wr_if.wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pattern_q", 32'(pattern_q), 32'b0001);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (4) begin
      tick();
      check("abort_quiet_wr_en", 32'(wr_if.wr_en), 32'd0);
      check("abort_quiet_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    check("abort_write_total", 32'(write_count - base_w), 32'd5);
    check("abort_no_done", 32'(done_count - base_d), 32'd0);
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

    // start held high: two back-to-back clear loads
    base_d = done_count;
    run_load(CLEAR, 64'h0, 4'b0001, -1, 0, -1, 1'b1);
    run_load(CLEAR, 64'h0, 4'b0001, -1, 0, -1, 1'b1);
    start = 1'b0;
    tick();
    check("held_start_stop_state", 32'(state_dbg), 32'(ST_IDLE));
    check("held_start_done_pulses", 32'(done_count - base_d), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
